// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write-back controller.
package rf_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;
    localparam int NREG   = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    function automatic req_e other_req(input req_e r);
        return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req/grant bit 0 is ALU, bit 1 is MEM.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_e prio_r;

    // One-hot grant from the request vector and the priority pointer
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (prio_r == REQ_ALU) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    // Priority pointer flips to the loser after every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= REQ_ALU;
        end else if (grant[0]) begin
            prio_r <= other_req(REQ_ALU);
        end else if (grant[1]) begin
            prio_r <= other_req(REQ_MEM);
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller: clear sequence, ALU/MEM round-robin, registered write stage.
// Define RF_WB_BYPASS_EN to forward the in-flight write onto data_out1/data_out2.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wa,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_wa,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          rf_write_enable,
    output logic [AW-1:0] rf_WA,
    output logic [DW-1:0] rf_data_in,
    output logic          init_done,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    input  logic [DW-1:0] rf_data_out1,
    input  logic [DW-1:0] rf_data_out2,
    output logic [DW-1:0] data_out1,
    output logic [DW-1:0] data_out2
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    state_e        state_r;
    logic [AW-1:0] init_cnt_r;
    logic          we_r;
    logic [AW-1:0] wa_r;
    logic [DW-1:0] wd_r;
    logic          done_r;
    logic [1:0]    grant_s;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state_r == RUN),
        .req   ({mem_valid, alu_valid}),
        .grant (grant_s)
    );

    assign alu_ready       = grant_s[0];
    assign mem_ready       = grant_s[1];
    assign rf_write_enable = we_r;
    assign rf_WA           = wa_r;
    assign rf_data_in      = wd_r;
    assign init_done       = done_r;

    // Clear sequence, then the registered write stage fed by the arbiter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
            we_r       <= 1'b0;
            wa_r       <= '0;
            wd_r       <= '0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    we_r       <= 1'b1;
                    wa_r       <= init_cnt_r;
                    wd_r       <= '0;
                    init_cnt_r <= init_cnt_r + AW'(1);
                    if (init_cnt_r == LAST_ADDR) begin
                        state_r <= RUN;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= INIT;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    case (grant_s)
                        2'b01: begin
                            we_r <= 1'b1;
                            wa_r <= alu_wa;
                            wd_r <= alu_data;
                        end
                        2'b10: begin
                            we_r <= 1'b1;
                            wa_r <= mem_wa;
                            wd_r <= mem_data;
                        end
                        default: begin
                            we_r <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_r    <= INIT;
                    init_cnt_r <= '0;
                    we_r       <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Forward the write being presented this cycle to matching readers
    always_comb begin
        if (we_r && (wa_r == RA1)) begin
            data_out1 = wd_r;
        end else begin
            data_out1 = rf_data_out1;
        end
        if (we_r && (wa_r == RA2)) begin
            data_out2 = wd_r;
        end else begin
            data_out2 = rf_data_out2;
        end
    end
`else
    assign data_out1 = rf_data_out1;
    assign data_out2 = rf_data_out2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised scoreboard bench for rf_wb_arbiter with a behavioural register-file model.
module tb_rf_wb_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_wa = '0, mem_wa = '0, RA1 = '0, RA2 = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, rf_write_enable, init_done;
    logic [AW-1:0] rf_WA;
    logic [DW-1:0] rf_data_in, rf_data_out1, rf_data_out2, data_out1, data_out2;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_write_enable(rf_write_enable), .rf_WA(rf_WA), .rf_data_in(rf_data_in),
        .init_done(init_done), .RA1(RA1), .RA2(RA2),
        .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
        .data_out1(data_out1), .data_out2(data_out2)
    );

    // Register file with no reset: starts full of garbage
    logic [DW-1:0] rf_mem [NREG] = '{default: 16'hDEAD};
    always @(posedge clk) if (rf_write_enable) rf_mem[rf_WA] <= rf_data_in;
    assign rf_data_out1 = rf_mem[RA1];
    assign rf_data_out2 = rf_mem[RA2];

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int tests = 0, fails = 0, writes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
    } wr_t;
    wr_t q[$];

    // Reference state: architectural register contents and round-robin preference
    logic [DW-1:0] arch_now [NREG];
    logic [DW-1:0] arch_lag [NREG];
    bit pref_alu = 1'b1;
    bit alu_hs = 1'b0, mem_hs = 1'b0;

    initial begin : monitor
        bit ea, em;
        wr_t e;
        logic [DW-1:0] x1, x2;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_we", rf_write_enable, 1'b0);
                chk("rst_ready", {alu_ready, mem_ready}, 2'b00);
                chk("rst_done", init_done, 1'b0);
                q.delete();
                pref_alu = 1'b1;
                alu_hs = 1'b0;
                mem_hs = 1'b0;
                for (int i = 0; i < NREG; i++) begin
                    arch_now[i] = '0;
                    arch_lag[i] = '0;
                end
            end else begin
                chk("init_done", init_done, cyc >= NREG);
                chk("we_vs_sb", rf_write_enable, q.size() != 0);
                if (rf_write_enable && q.size() != 0) begin
                    e = q.pop_front();
                    chk("wr_addr", rf_WA, e.wa);
                    chk("wr_data", rf_data_in, e.d);
                    writes++;
                end
                q.delete();
                if (cyc >= NREG + 1) begin
`ifdef RF_WB_BYPASS_EN
                    x1 = arch_now[RA1];
                    x2 = arch_now[RA2];
`else
                    x1 = arch_lag[RA1];
                    x2 = arch_lag[RA2];
`endif
                    chk("data_out1", data_out1, x1);
                    chk("data_out2", data_out2, x2);
                end
                arch_lag = arch_now;
                if (cyc < NREG) begin
                    chk("ready_in_init", {alu_ready, mem_ready}, 2'b00);
                    q.push_back('{wa: AW'(cyc), d: '0});
                    alu_hs = 1'b0;
                    mem_hs = 1'b0;
                end else begin
                    ea = alu_valid && (!mem_valid || pref_alu);
                    em = mem_valid && (!alu_valid || !pref_alu);
                    chk("alu_ready", alu_ready, ea);
                    chk("mem_ready", mem_ready, em);
                    if (ea) begin
                        q.push_back('{wa: alu_wa, d: alu_data});
                        arch_now[alu_wa] = alu_data;
                        pref_alu = 1'b0;
                    end else if (em) begin
                        q.push_back('{wa: mem_wa, d: mem_data});
                        arch_now[mem_wa] = mem_data;
                        pref_alu = 1'b1;
                    end
                    alu_hs = alu_valid && alu_ready;
                    mem_hs = mem_valid && mem_ready;
                end
            end
        end
    end

    int p_alu = 0, p_mem = 0, mode = 0;

    // One cycle of requester behaviour: hold until accepted, then maybe issue again
    task automatic step();
        @(posedge clk);
        #1;
        if (!alu_valid || alu_hs) begin
            alu_valid = ($urandom_range(0, 99) < p_alu);
            alu_wa    = (mode == 1) ? 4'd1 : (mode == 2) ? 4'd7 : AW'($urandom);
            alu_data  = (mode == 1) ? 16'hAAAA : (mode == 2) ? 16'h0001 : DW'($urandom);
        end
        if (!mem_valid || mem_hs) begin
            mem_valid = ($urandom_range(0, 99) < p_mem);
            mem_wa    = (mode == 1) ? 4'd2 : (mode == 2) ? 4'd7 : AW'($urandom);
            mem_data  = (mode == 1) ? 16'h5555 : (mode == 2) ? 16'h0002 : DW'($urandom);
        end
        RA1 = (mode == 2) ? 4'd7 : AW'($urandom);
        RA2 = AW'($urandom);
    endtask

    task automatic run(input int n, input int pa, input int pm, input int md);
        p_alu = pa;
        p_mem = pm;
        mode  = md;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mid_reset();
        step();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        run(24, 0, 0, 0);
        run(4, 100, 0, 0);
        run(8, 100, 100, 1);
        run(6, 100, 100, 2);
        run(6, 0, 0, 0);
        run(800, 50, 50, 0);
        run(20, 100, 100, 0);
        mid_reset();
        run(400, 70, 40, 0);
        run(10, 100, 100, 2);
        mid_reset();
        run(30, 100, 100, 0);
        run(800, 30, 80, 0);
        run(6, 0, 0, 0);
        chk("writes_seen", writes > 500, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 16×16-bit general-purpose register file. It owns the register file's single write port. After reset it runs an initialisation sequence that clears all 16 registers, because the register file itself has no reset. It then arbitrates round-robin between the ALU and memory-load write-back requesters using a valid/ready handshake, and drives a registered write stage into the register file.

## Interface
Parameters:
- DW, 16, data width of a register / write-back word
- AW, 4, register address width (2^AW registers)

Ports (clock and reset first):
- clk  input  1  system clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU write-back request
- alu_wa  input  AW  ALU destination register
- alu_data  input  DW  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load write-back request
- mem_wa  input  AW  load destination register
- mem_data  input  DW  load data
- mem_ready  output  1  load request accepted this cycle
- rf_write_enable  output  1  register file write strobe (registered)
- rf_WA  output  AW  register file write address (registered)
- rf_data_in  output  DW  register file write data (registered)
- init_done  output  1  high once the clear sequence has completed
- RA1, RA2  input  AW  read addresses, as presented to the register file (used for bypass)
- rf_data_out1, rf_data_out2  input  DW  raw register file read data
- data_out1, data_out2  output  DW  read data delivered to the datapath

## Operation
- FSM states are INIT and RUN. Asynchronous reset forces INIT with init_cnt=0.
- Reset values of all outputs are 0; data_out1/2 are pure combinational (see Configuration).
- INIT:
  - Each cycle, register rf_write_enable=1, rf_WA=init_cnt, rf_data_in=0, then increment init_cnt.
  - After the write to address 15 is issued, go to RUN and set init_done=1.
  - alu_ready=mem_ready=0 throughout INIT.
- RUN: requester rules
  - Requesters hold valid, wa and data stable until ready.
  - ready is combinational from valid and the priority pointer.
  - The output stage drains every cycle, so it never back-pressures.
- RUN: arbitration
  - One requester only valid → it is granted.
  - Both valid → the one named by the prio flop is granted.
  - Neither valid → nothing is granted.
  - After any grant, prio points to the other requester. Reset value is prio=ALU.
- RUN: write stage
  - On a grant, register rf_write_enable=1 with the granted wa/data.
  - With no grant, rf_write_enable=0; rf_WA/rf_data_in hold their last value.
- Both requesters targeting the same register are serialised. The later grant overwrites: last write wins.
- Reset asserted mid-INIT or mid-RUN:
  - Any in-flight write is dropped (rf_write_enable=0 immediately).
  - The clear sequence restarts at address 0.

## Timing
- Handshake accepted at edge N (valid&ready=1 before N).
- rf_write_enable/rf_WA/rf_data_in are valid in cycle N..N+1; the register file captures at edge N+1.
- Written data is visible on the raw read port after N+1; with bypass it is visible during cycle N..N+1.
- INIT lasts exactly 16 cycles after reset release.
- init_done rises at the edge that registers the address-15 write. The first grant is possible in the following cycle.
- Throughput: one write-back per cycle. A requester contending continuously gets at least every other cycle.

## Configuration
- RF_WB_BYPASS_EN defined:
  - data_outK = rf_data_in when rf_write_enable && rf_WA==RAK; otherwise rf_data_outK.
  - This forwards the in-flight write to the readers.
- RF_WB_BYPASS_EN undefined: data_outK = rf_data_outK unconditionally, and readers see the write one cycle later.

## Structure
- Package rf_pkg holds:
  - the DW/AW defaults and the register count
  - typedef enum for FSM state {INIT, RUN}
  - typedef enum for requester {REQ_ALU, REQ_MEM}
- One sub-module, rr_arb2: a two-requester round-robin arbiter. It owns the prio flop and outputs a one-hot grant.

## Test plan
- Reset release with no requests:
  - rf_write_enable=1 for 16 cycles with rf_WA=0..15 and data 0.
  - init_done=1 after that; both ready=0 throughout.
- RUN, alu_valid only, wa=3, data=0x1234:
  - alu_ready=1.
  - Next cycle: rf_write_enable=1, rf_WA=3, rf_data_in=0x1234.
- Both valid for 4 cycles (ALU wa=1/0xAAAA, MEM wa=2/0x5555) with prio=ALU: grants alternate ALU, MEM, ALU, MEM.
- Both valid with the same wa=7, ALU=0x0001, MEM=0x0002: final reg7 value is 0x0002.
- With RF_WB_BYPASS_EN: write wa=5 of 0xBEEF with RA1=5 → data_out1=0xBEEF in the write cycle. Without the macro, data_out1=0xBEEF only one cycle later.
- Reset asserted during RUN, mid-stream: rf_write_enable falls to 0 immediately, and INIT restarts at rf_WA=0.
